mul_sequencer: RTL and testbench

Multi-cycle unsigned multiply controller that borrows the datapath's shared 32-bit ALU for shift-and-add iterations, so integer multiply needs no dedicated multiplier array. It accepts a start pulse with two operands, drives the ALU's control and operand inputs with an ADD each iteration, captures the ALU result, and returns the low WIDTH bits of the product with a one-cycle done strobe. It sits beside the ALU in the execute stage. The pipeline stalls on `busy`.

---
 rtl/mul_sequencer_pkg.sv | 20 ++
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/alu.sv | 27 ++
 rtl/mul_sequencer.sv | 89 ++++++++
 tb/tb_mul_sequencer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared ALU definitions: control codes understood by the execute-stage ALU
// and the state encoding of the multiply sequencer that borrows it.
// No ports; imported by the ALU and by mul_sequencer.
package mul_sequencer_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the execute stage and mul_sequencer.
//   start        request pulse with operands op_a (multiplicand), op_b (multiplier)
//   busy / done  stall indication and one-cycle completion strobe
//   result       low WIDTH bits of the product; result_zero flags result == 0
// master: the requester (pipeline / testbench); slave: the sequencer.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_zero;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, result_zero
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, result_zero
    );
endinterface

// File: rtl/alu.sv
// Combinational execute-stage ALU shared with the multiply sequencer.
//   alu_control  4-bit operation code (see mul_sequencer_pkg)
//   input1/2     operands
//   alu_out      result; unknown codes (including ALU_IDLE) give 0
module alu
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] alu_out
);
    always_comb begin
        alu_out = '0;
        case (alu_control)
            ALU_AND: alu_out = input1 & input2;
            ALU_OR:  alu_out = input1 | input2;
            ALU_ADD: alu_out = input1 + input2;
            ALU_SUB: alu_out = input1 - input2;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
            ALU_NOR: alu_out = ~(input1 | input2);
            default: alu_out = '0;
        endcase
    end
endmodule

// File: rtl/mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU for its adds.
//   clock, reset   rising-edge clock, synchronous active-low reset
//   bus (slave)    start/op_a/op_b request, busy/done/result/result_zero response
//   alu_control    ALU_ADD while iterating, ALU_IDLE otherwise
//   alu_in1/in2    accumulator and shifted multiplicand while iterating, else 0
//   alu_out        same-cycle ALU sum, captured into the accumulator
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] ADD_CODE  = ALU_ADD,
    parameter logic [3:0] IDLE_CODE = ALU_IDLE
) (
    input  logic             clock,
    input  logic             reset,
    mul_sequencer_if.slave   bus,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out
);
    seq_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic             busy;
    logic             done;
    logic             alu_own;

    // busy/done/alu_own are registered alongside the state so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_own <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc     <= '0;
                        mcand   <= bus.op_a;
                        mplr    <= bus.op_b;
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        alu_own <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mplr[0]) begin
                        acc <= alu_out;
                    end
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    // Stop once no set multiplier bits remain above this one.
                    if ((mplr >> 1) == '0) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        alu_own <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    alu_own <= 1'b0;
                end
            endcase
        end
    end

    assign alu_control     = alu_own ? ADD_CODE : IDLE_CODE;
    assign alu_in1         = alu_own ? acc : '0;
    assign alu_in2         = alu_own ? mcand : '0;

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.result      = acc;
    assign bus.result_zero = (acc == '0);
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer wired to the shared ALU.
module tb_mul_sequencer;
    logic        clock;
    logic        reset;
    logic [3:0]  alu_control;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;

    int unsigned vectors;
    int unsigned miscompares;

    mul_sequencer_if #(.WIDTH(32)) bus ();

    mul_sequencer #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .alu_control (alu_control),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_out     (alu_out)
    );

    alu #(.WIDTH(32)) u_alu (
        .alu_control (alu_control),
        .input1      (alu_in1),
        .input2      (alu_in2),
        .alu_out     (alu_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a multiply at the next edge and follow it through DONE and back to IDLE.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned exp_runs, input logic [31:0] exp_res);
        int unsigned runs;
        runs = 0;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ".first_in1"}, alu_in1, 32'h0);
        check({tag, ".first_in2"}, alu_in2, a);
        for (int i = 0; i < 40 && bus.done !== 1'b1; i++) begin
            check({tag, ".run_ctrl"}, {28'h0, alu_control}, 32'h2);
            check({tag, ".run_busy"}, {31'h0, bus.busy}, 32'h1);
            runs++;
            tick();
        end
        check({tag, ".done"}, {31'h0, bus.done}, 32'h1);
        check({tag, ".runs"}, runs, exp_runs);
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".rzero"}, {31'h0, bus.result_zero}, {31'h0, exp_res == 32'h0});
        check({tag, ".done_busy"}, {31'h0, bus.busy}, 32'h1);
        check({tag, ".done_ctrl"}, {28'h0, alu_control}, 32'hF);
        tick();
        check({tag, ".idle_done"}, {31'h0, bus.done}, 32'h0);
        check({tag, ".idle_busy"}, {31'h0, bus.busy}, 32'h0);
        check({tag, ".idle_ctrl"}, {28'h0, alu_control}, 32'hF);
        check({tag, ".idle_in1"}, alu_in1, 32'h0);
        check({tag, ".held"}, bus.result, exp_res);
    endtask

    initial begin
        int unsigned dones;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op_a    = 32'h0;
        bus.op_b    = 32'h0;
        tick();
        tick();
        check("rst.busy",  {31'h0, bus.busy}, 32'h0);
        check("rst.done",  {31'h0, bus.done}, 32'h0);
        check("rst.result", bus.result, 32'h0);
        check("rst.rzero", {31'h0, bus.result_zero}, 32'h1);
        check("rst.ctrl",  {28'h0, alu_control}, 32'hF);
        check("rst.in1",   alu_in1, 32'h0);
        check("rst.in2",   alu_in2, 32'h0);
        reset = 1'b1;
        tick();

        run_mul("basic",   32'd6,        32'd7,        3,  32'd42);
        run_mul("zero",    32'h1234,     32'h0,        1,  32'h0);
        run_mul("ovf",     32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h1);
        run_mul("msb",     32'd3,        32'h80000000, 32, 32'h80000000);

        // start pulsed during RUN must be ignored
        bus.op_a = 32'd5; bus.op_b = 32'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.op_a = 32'd2; bus.op_b = 32'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                check("busy_start.result", bus.result, 32'd45);
            end
            tick();
        end
        check("busy_start.dones", dones, 1);
        check("busy_start.held", bus.result, 32'd45);

        // start held high is re-accepted on the IDLE cycle after DONE
        bus.op_a = 32'd2; bus.op_b = 32'd3; bus.start = 1'b1;
        tick();
        tick();
        tick();
        check("hold.done", {31'h0, bus.done}, 32'h1);
        check("hold.result", bus.result, 32'd6);
        tick();
        check("hold.idle_busy", {31'h0, bus.busy}, 32'h0);
        tick();
        bus.start = 1'b0;
        check("hold.reaccept_busy", {31'h0, bus.busy}, 32'h1);
        check("hold.reaccept_clr", bus.result, 32'h0);
        for (int i = 0; i < 10 && bus.done !== 1'b1; i++) tick();
        check("hold.done2", {31'h0, bus.done}, 32'h1);
        check("hold.result2", bus.result, 32'd6);
        tick();

        // reset in the second RUN cycle
        bus.op_a = 32'hFFFF; bus.op_b = 32'hFFFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("midrst.running", {31'h0, bus.busy}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst.busy", {31'h0, bus.busy}, 32'h0);
        check("midrst.done", {31'h0, bus.done}, 32'h0);
        check("midrst.result", bus.result, 32'h0);
        check("midrst.rzero", {31'h0, bus.result_zero}, 32'h1);
        check("midrst.ctrl", {28'h0, alu_control}, 32'hF);
        run_mul("after_rst", 32'd4, 32'd4, 3, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
